// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the fetch-control stage: FSM encodings, fetch
// geometry and the default reset vector.
package pc_ctrl_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned INST_BYTES = 4;
    localparam int unsigned CNT_W      = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_REDIR = 1'b1
    } pc_state_t;

    // Force a fetch target onto a word boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_ctrl_stats.sv
// Saturating event counters for branch, taken-redirect and fetch-stall cycles.
// Instantiated by pc_ctrl only when PC_CTRL_STATS_EN is defined.
module pc_ctrl_stats
    import pc_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             hold_en,
    input  logic             jump_en,
    input  logic             if_valid,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] fetch_stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt <= '0;
        end else if (hold_en && (branch_cnt != CNT_MAX)) begin
            branch_cnt <= branch_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taken_cnt <= '0;
        end else if (jump_en && (taken_cnt != CNT_MAX)) begin
            taken_cnt <= taken_cnt + CNT_ONE;
        end
    end

    // rst is low in this branch, so only the if_valid term matters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_stall_cnt <= '0;
        end else if (!if_valid && (fetch_stall_cnt != CNT_MAX)) begin
            fetch_stall_cnt <= fetch_stall_cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/pc_ctrl.sv
// Fetch control: program counter, imem handshake, redirect handling and
// pipeline flush strobes. Optional statistics under PC_CTRL_STATS_EN.
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            jump_en,
    input  logic [XLEN-1:0] jump_addr,
    input  logic            hold_en,
    input  logic            imem_ready,
    output logic [XLEN-1:0] pc,
    output logic            if_valid,
    output logic            flush_if_id,
    output logic            flush_id_ex
`ifdef PC_CTRL_STATS_EN
    ,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] fetch_stall_cnt
`endif
);

    pc_state_t       state;
    pc_state_t       state_n;
    logic [XLEN-1:0] pc_n;
    logic [XLEN-1:0] redirect_addr;
    logic [XLEN-1:0] redirect_addr_n;
    logic [XLEN-1:0] target;

    assign target = word_align(jump_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_RUN;
            pc            <= RESET_PC;
            redirect_addr <= '0;
        end else begin
            state         <= state_n;
            pc            <= pc_n;
            redirect_addr <= redirect_addr_n;
        end
    end

    // An outstanding imem request cannot be cancelled, so a redirect seen
    // while imem is busy is parked in redirect_addr until the word returns.
    always_comb begin
        state_n         = state;
        pc_n            = pc;
        redirect_addr_n = redirect_addr;
        if_valid        = 1'b0;
        flush_if_id     = 1'b0;
        flush_id_ex     = 1'b0;

        unique case (state)
            ST_RUN: begin
                if (jump_en) begin
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                    if (imem_ready) begin
                        pc_n = target;
                    end else begin
                        redirect_addr_n = target;
                        state_n         = ST_REDIR;
                    end
                end else if (imem_ready) begin
                    if_valid = 1'b1;
                    pc_n     = pc + XLEN'(INST_BYTES);
                end
            end
            ST_REDIR: begin
                if (jump_en) begin
                    flush_if_id     = 1'b1;
                    flush_id_ex     = 1'b1;
                    redirect_addr_n = target;
                end
                if (imem_ready) begin
                    pc_n    = jump_en ? target : redirect_addr;
                    state_n = ST_RUN;
                end
            end
            default: begin
                state_n = ST_RUN;
            end
        endcase

        if (rst) begin
            if_valid    = 1'b0;
            flush_if_id = 1'b0;
            flush_id_ex = 1'b0;
        end
    end

`ifdef PC_CTRL_STATS_EN
    pc_ctrl_stats u_stats (
        .clk             (clk),
        .rst             (rst),
        .hold_en         (hold_en),
        .jump_en         (jump_en),
        .if_valid        (if_valid),
        .branch_cnt      (branch_cnt),
        .taken_cnt       (taken_cnt),
        .fetch_stall_cnt (fetch_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl: sequential fetch, redirects with and without
// imem busy, wrap-around, reset during REDIR, optional statistics.
module tb_pc_ctrl;

    logic        clk;
    logic        rst;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        hold_en;
    logic        imem_ready;
    logic [31:0] pc;
    logic        if_valid;
    logic        flush_if_id;
    logic        flush_id_ex;
`ifdef PC_CTRL_STATS_EN
    logic [31:0] branch_cnt;
    logic [31:0] taken_cnt;
    logic [31:0] fetch_stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    pc_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .hold_en     (hold_en),
        .imem_ready  (imem_ready),
        .pc          (pc),
        .if_valid    (if_valid),
        .flush_if_id (flush_if_id),
        .flush_id_ex (flush_id_ex)
`ifdef PC_CTRL_STATS_EN
        ,
        .branch_cnt      (branch_cnt),
        .taken_cnt       (taken_cnt),
        .fetch_stall_cnt (fetch_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge, then settle.
    task automatic drive(input logic r, input logic j, input logic [31:0] ja,
                         input logic h, input logic rdy);
        @(negedge clk);
        rst        = r;
        jump_en    = j;
        jump_addr  = ja;
        hold_en    = h;
        imem_ready = rdy;
        #1;
    endtask

    // Check pc, if_valid and both flushes for the current cycle.
    task automatic expect_cyc(input string tag, input logic [31:0] epc, input logic ev,
                              input logic ef);
        check({tag, ".pc"}, pc, epc);
        check({tag, ".if_valid"}, 32'(if_valid), 32'(ev));
        check({tag, ".flush_if_id"}, 32'(flush_if_id), 32'(ef));
        check({tag, ".flush_id_ex"}, 32'(flush_id_ex), 32'(ef));
    endtask

    initial begin
        rst = 1'b0; jump_en = 1'b0; jump_addr = '0; hold_en = 1'b0; imem_ready = 1'b1;
        #2 rst = 1'b1;

        // Reset held; strobes forced low even with a redirect request.
        drive(1, 1, 32'h0000_0040, 0, 1);
        expect_cyc("reset", 32'h0, 0, 0);

        // Sequential fetch from RESET_PC.
        drive(0, 0, 0, 0, 1); expect_cyc("seq0", 32'h00, 1, 0);
        drive(0, 0, 0, 0, 1); expect_cyc("seq1", 32'h04, 1, 0);
        drive(0, 0, 0, 0, 1); expect_cyc("seq2", 32'h08, 1, 0);
        drive(0, 0, 0, 0, 1); expect_cyc("seq3", 32'h0C, 1, 0);

        // Taken redirect with imem ready.
        drive(0, 1, 32'h40, 1, 1); expect_cyc("jmp_rdy", 32'h10, 0, 1);
        drive(0, 0, 0, 0, 1);      expect_cyc("tgt0", 32'h40, 1, 0);
        drive(0, 0, 0, 0, 1);      expect_cyc("tgt1", 32'h44, 1, 0);

        // Reposition to 0x20, then redirect while imem busy for 3 cycles.
        drive(0, 1, 32'h20, 0, 1); expect_cyc("to20", 32'h48, 0, 1);
        drive(0, 1, 32'h80, 1, 0); expect_cyc("jmp_busy", 32'h20, 0, 1);
        drive(0, 0, 0, 0, 0);      expect_cyc("redir1", 32'h20, 0, 0);
        drive(0, 0, 0, 0, 0);      expect_cyc("redir2", 32'h20, 0, 0);
        drive(0, 0, 0, 0, 1);      expect_cyc("redir_discard", 32'h20, 0, 0);
        drive(0, 0, 0, 0, 1);      expect_cyc("redir_tgt", 32'h80, 1, 0);

        // Not-taken branch costs no bubble.
        drive(0, 1, 32'h30, 0, 1); expect_cyc("to30", 32'h84, 0, 1);
        drive(0, 0, 0, 1, 1);      expect_cyc("nt_branch", 32'h30, 1, 0);
        drive(0, 1, 32'h43, 1, 1); expect_cyc("nt_next", 32'h34, 0, 1);

        // Misaligned target is word-aligned; then wrap past 0xFFFF_FFFC.
        drive(0, 1, 32'hFFFF_FFFC, 0, 1); expect_cyc("align", 32'h40, 0, 1);
        drive(0, 0, 0, 0, 1); expect_cyc("top", 32'hFFFF_FFFC, 1, 0);
        drive(0, 0, 0, 0, 1); expect_cyc("wrap", 32'h0, 1, 0);

        // Second jump in REDIR overwrites the pending target.
        drive(0, 1, 32'h100, 0, 0); expect_cyc("r2_enter", 32'h04, 0, 1);
        drive(0, 1, 32'h200, 0, 0); expect_cyc("r2_over", 32'h04, 0, 1);
        drive(0, 0, 0, 0, 1);       expect_cyc("r2_ret", 32'h04, 0, 0);
        drive(0, 0, 0, 0, 1);       expect_cyc("r2_tgt", 32'h200, 1, 0);

        // Jump coinciding with imem_ready in REDIR loads the new target directly.
        drive(0, 1, 32'h300, 0, 0); expect_cyc("r3_enter", 32'h204, 0, 1);
        drive(0, 1, 32'h400, 0, 1); expect_cyc("r3_win", 32'h204, 0, 1);
        drive(0, 0, 0, 0, 1);       expect_cyc("r3_tgt", 32'h400, 1, 0);
        drive(0, 0, 0, 0, 1);       expect_cyc("r3_next", 32'h404, 1, 0);

        // Reset during REDIR drops the pending redirect.
        drive(0, 1, 32'h500, 0, 0); expect_cyc("r4_enter", 32'h408, 0, 1);
        drive(1, 1, 32'h600, 0, 1); expect_cyc("r4_rst", 32'h0, 0, 0);
        drive(0, 0, 0, 0, 1);       expect_cyc("r4_restart", 32'h0, 1, 0);
        drive(0, 0, 0, 0, 1);       expect_cyc("r4_next", 32'h4, 1, 0);

        // Plain fetch stall in RUN.
        drive(0, 0, 0, 0, 0); expect_cyc("stall", 32'h8, 0, 0);
        drive(0, 0, 0, 0, 1); expect_cyc("stall_end", 32'h8, 1, 0);

`ifdef PC_CTRL_STATS_EN
        // Fresh reset, then 2 branches (1 taken), 3 stall cycles.
        drive(1, 0, 0, 0, 1);
        check("stats_rst_branch", branch_cnt, 32'd0);
        check("stats_rst_taken", taken_cnt, 32'd0);
        check("stats_rst_stall", fetch_stall_cnt, 32'd0);
        drive(0, 1, 32'h40, 1, 1);  // taken branch: if_valid=0
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 1);       // not-taken branch
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1);
        check("stats_branch", branch_cnt, 32'd2);
        check("stats_taken", taken_cnt, 32'd1);
        check("stats_stall", fetch_stall_cnt, 32'd4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Fetch-control stage of the 3-stage RV32I core. It owns the program counter and the instruction-memory fetch handshake, and acts on the branch resolution produced by the execute stage (`jump_en`, `jump_addr`, `hold_en`). It generates flush strobes for the IF/ID and ID/EX pipeline registers. It sits upstream of IF/ID and closes the control loop from execute back to fetch.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: core clock.
- `rst` in 1: asynchronous, active-high reset.
- `jump_en` in 1: execute stage requests a redirect this cycle.
- `jump_addr` in 32: redirect target; bits [1:0] ignored and treated as 0.
- `hold_en` in 1: a branch instruction is being resolved in execute (taken or not).
- `imem_ready` in 1: instruction memory has returned the word for `pc` this cycle.
- `pc` out 32: current fetch address, driven to imem and the IF/ID `inst_addr` field.
- `if_valid` out 1: IF/ID captures the imem word this cycle; otherwise it loads a bubble.
- `flush_if_id` out 1: clear IF/ID at the next edge.
- `flush_id_ex` out 1: clear ID/EX at the next edge.
- `branch_cnt`, `taken_cnt`, `fetch_stall_cnt` out 32 each: present only with `PC_CTRL_STATS_EN`.

## Operation
- States: RUN and REDIR.
  - REDIR means a redirect is pending while an imem fetch is still outstanding.
  - An outstanding imem request cannot be cancelled.
- Internal `redirect_addr` register, 32 bits.
- RUN, `jump_en`=1:
  - `flush_if_id`=`flush_id_ex`=1 and `if_valid`=0.
  - If `imem_ready`=1: `pc`<=`{jump_addr[31:2],2'b00}`, stay in RUN.
  - If `imem_ready`=0: `redirect_addr`<=`{jump_addr[31:2],2'b00}`, `pc` holds, go to REDIR.
- RUN, `jump_en`=0:
  - If `imem_ready`=1: `if_valid`=1, `pc`<=`pc+4`.
  - If `imem_ready`=0: `if_valid`=0 and `pc` holds (fetch stall; IF/ID loads a bubble while downstream keeps running).
- REDIR:
  - `if_valid`=0 always; the returning word is wrong-path and is discarded.
  - When `imem_ready`=1: `pc`<=`redirect_addr`, go to RUN.
  - A further `jump_en` in REDIR overwrites `redirect_addr` and asserts both flushes. If `imem_ready` is also 1 that cycle, the new `jump_addr` wins and is loaded into `pc` directly.
- `hold_en` has no effect on control flow. A not-taken branch (`hold_en`=1, `jump_en`=0) costs no bubble. `jump_en` without `hold_en` (future JAL/JALR) is legal and handled identically.
- Arithmetic: `pc+4` is modulo 2^32; 32'hFFFF_FFFC wraps to 0.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, state RUN, `redirect_addr`=0, all counters 0.
  - While `rst`=1: `if_valid`, `flush_if_id`, `flush_id_ex` are 0.
- `pc` is registered.
- `if_valid`, `flush_if_id`, `flush_id_ex` are combinational from state, `jump_en` and `imem_ready`, and are valid in the same cycle.
- Taken-branch penalty:
  - 2 bubbles when `imem_ready` is high: the instructions in IF and ID are flushed, and the target is fetched in the cycle after `jump_en`.
  - If imem is busy, penalty is 2 plus the cycles spent in REDIR.
- Reset asserted mid-REDIR: the pending redirect is dropped and fetch restarts at `RESET_PC` after `rst` falls.
- First fetch of `RESET_PC` occurs in the first cycle with `rst`=0.

## Configuration
- `PC_CTRL_STATS_EN` defined: three 32-bit saturating counters and their output ports are compiled in.
  - `branch_cnt` +1 per cycle with `hold_en`=1.
  - `taken_cnt` +1 per cycle with `jump_en`=1.
  - `fetch_stall_cnt` +1 per cycle with `if_valid`=0 and `rst`=0.
  - Each counter saturates at 32'hFFFF_FFFF.
- `PC_CTRL_STATS_EN` undefined: counters and ports are absent; control behaviour is identical.

## Structure
- Shared defines file: state encodings (RUN=1'b0, REDIR=1'b1), `INST_BYTES`=4, default `RESET_PC`.
- One sub-module, `pc_ctrl_stats`, holds the counters. It is instantiated only under `PC_CTRL_STATS_EN`.
- The FSM, PC and redirect register stay in `pc_ctrl`.

## Test plan
- Reset release with `imem_ready`=1 constant -> `pc` = 0, 4, 8, 12 on successive cycles; `if_valid`=1 each cycle; flushes stay 0.
- At `pc`=0x10, pulse `jump_en`=1 with `jump_addr`=0x40 and `imem_ready`=1 -> both flushes and `if_valid`=0 that cycle; next cycle `pc`=0x40, then 0x44.
- At `pc`=0x20, `imem_ready`=0 for 3 cycles, with `jump_en`=1 and `jump_addr`=0x80 in the first -> state REDIR, `pc` holds 0x20, `if_valid`=0; on the `imem_ready` cycle the word is discarded; next cycle `pc`=0x80.
- `hold_en`=1, `jump_en`=0 at `pc`=0x30 -> no flush; `pc`=0x34 next cycle (not-taken branch costs no bubble).
- `jump_addr`=0x43 taken -> `pc`=0x40. Run from 0xFFFF_FFFC -> `pc` wraps to 0. Assert `rst` during REDIR -> `pc`=`RESET_PC` immediately, state RUN.
- With `PC_CTRL_STATS_EN`: 2 branches (1 taken) plus 3 stall cycles -> `branch_cnt`=2, `taken_cnt`=1, `fetch_stall_cnt`=3 plus the bubble cycles counted under the `if_valid`=0 rule.
